// File: rtl/bram_dp_pkg.sv
// Shared encodings for the dual-port block RAM: read-during-write modes
// and the clear-sweep FSM state type.
package bram_dp_pkg;

    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/bram_dp_clr_fsm.sv
// Clear-sweep controller: walks the address space writing zero, one word per
// cycle; entered on reset and on a clr request while idle.
module bram_dp_clr_fsm
    import bram_dp_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we
);

    clr_state_t        state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            cnt    <= '0;
            busy   <= 1'b1;
            clr_we <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (clr) begin
                        state  <= CLEAR;
                        busy   <= 1'b1;
                        clr_we <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clr is deliberately not sampled here: no restart mid-sweep
                    if (cnt == '1) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        clr_we <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign clr_addr = cnt;

endmodule

// File: rtl/bram_dp_param.sv
// Dual-port RAM with byte-lane writes, selectable read-during-write mode and a
// hardware clear sweep. Define BRAM_DP_OUTREG_EN for an extra output stage.
module bram_dp_param
    import bram_dp_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int LANE_W  = 4,
    parameter int ADDR_W  = 5,
    parameter int WR_MODE = WR_READ_FIRST
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    output logic                       busy,
    input  logic                       we,
    input  logic [DATA_W/LANE_W-1:0]   be,
    input  logic [ADDR_W-1:0]          a,
    input  logic [DATA_W-1:0]          di,
    input  logic                       re,
    input  logic [ADDR_W-1:0]          dpra,
    input  logic                       dre,
    output logic [DATA_W-1:0]          spo,
    output logic                       spo_vld,
    output logic [DATA_W-1:0]          dpo,
    output logic                       dpo_vld
);

    localparam int NUM_LANES = DATA_W / LANE_W;
    localparam int DEPTH     = 2 ** ADDR_W;

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0]    old_d,
        input logic [DATA_W-1:0]    wdat,
        input logic [NUM_LANES-1:0] en
    );
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (en[i]) r[i*LANE_W +: LANE_W] = wdat[i*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              wr_ok;
    logic              rd_a_ok;
    logic              rd_b_ok;
    logic [DATA_W-1:0] merged_a;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    bram_dp_clr_fsm #(
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .busy     (busy),
        .clr_addr (clr_addr),
        .clr_we   (clr_we)
    );

    // A clr request takes the cycle: any user access alongside it is dropped.
    assign wr_ok   = we  & ~busy & ~clr;
    assign rd_a_ok = re  & ~busy & ~clr;
    assign rd_b_ok = dre & ~busy & ~clr;

    assign merged_a = lane_merge(mem[a], di, be);
    assign rdata_a  = (WR_MODE == WR_WRITE_FIRST && wr_ok) ? merged_a : mem[a];
    assign rdata_b  = (WR_MODE == WR_WRITE_FIRST && wr_ok && dpra == a) ? merged_a : mem[dpra];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem[a] <= merged_a;
        end
    end

    // stage p0: array read
    logic [DATA_W-1:0] spo_p0;
    logic [DATA_W-1:0] dpo_p0;
    logic              vld_a_p0;
    logic              vld_b_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spo_p0   <= '0;
            dpo_p0   <= '0;
            vld_a_p0 <= 1'b0;
            vld_b_p0 <= 1'b0;
        end else begin
            vld_a_p0 <= rd_a_ok;
            vld_b_p0 <= rd_b_ok;
            if (rd_a_ok) spo_p0 <= rdata_a;
            if (rd_b_ok) dpo_p0 <= rdata_b;
        end
    end

`ifdef BRAM_DP_OUTREG_EN
    // stage p1: optional output register
    logic [DATA_W-1:0] spo_p1;
    logic [DATA_W-1:0] dpo_p1;
    logic              vld_a_p1;
    logic              vld_b_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spo_p1   <= '0;
            dpo_p1   <= '0;
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
        end else begin
            vld_a_p1 <= vld_a_p0;
            vld_b_p1 <= vld_b_p0;
            if (vld_a_p0) spo_p1 <= spo_p0;
            if (vld_b_p0) dpo_p1 <= dpo_p0;
        end
    end

    assign spo     = spo_p1;
    assign dpo     = dpo_p1;
    assign spo_vld = vld_a_p1;
    assign dpo_vld = vld_b_p1;
`else
    assign spo     = spo_p0;
    assign dpo     = dpo_p0;
    assign spo_vld = vld_a_p0;
    assign dpo_vld = vld_b_p0;
`endif

endmodule

// File: tb/tb_bram_dp_param.sv
// Directed bench for bram_dp_param: read-first, write-first and 16/8-lane
// instances share the control inputs.
module tb_bram_dp_param;

`ifdef BRAM_DP_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic        we    = 1'b0;
    logic        re    = 1'b0;
    logic        dre   = 1'b0;
    logic [4:0]  a     = '0;
    logic [4:0]  dpra  = '0;
    logic [3:0]  di    = '0;
    logic        be    = 1'b0;
    logic [15:0] di16  = '0;
    logic [1:0]  be16  = '0;

    logic        busy_rf, spo_vld_rf, dpo_vld_rf;
    logic [3:0]  spo_rf, dpo_rf;
    logic        busy_wf, spo_vld_wf, dpo_vld_wf;
    logic [3:0]  spo_wf, dpo_wf;
    logic        busy_ln, spo_vld_ln, dpo_vld_ln;
    logic [15:0] spo_ln, dpo_ln;

    int errors = 0;
    int checks = 0;
    int n;
    bit vld_seen;

    always #5 clk = ~clk;

    bram_dp_param #(.DATA_W(4), .LANE_W(4), .ADDR_W(5), .WR_MODE(0)) dut_rf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_rf), .we(we), .be(be),
        .a(a), .di(di), .re(re), .dpra(dpra), .dre(dre),
        .spo(spo_rf), .spo_vld(spo_vld_rf), .dpo(dpo_rf), .dpo_vld(dpo_vld_rf)
    );

    bram_dp_param #(.DATA_W(4), .LANE_W(4), .ADDR_W(5), .WR_MODE(1)) dut_wf (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_wf), .we(we), .be(be),
        .a(a), .di(di), .re(re), .dpra(dpra), .dre(dre),
        .spo(spo_wf), .spo_vld(spo_vld_wf), .dpo(dpo_wf), .dpo_vld(dpo_vld_wf)
    );

    bram_dp_param #(.DATA_W(16), .LANE_W(8), .ADDR_W(5), .WR_MODE(0)) dut_ln (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_ln), .we(we), .be(be16),
        .a(a), .di(di16), .re(re), .dpra(dpra), .dre(dre),
        .spo(spo_ln), .spo_vld(spo_vld_ln), .dpo(dpo_ln), .dpo_vld(dpo_vld_ln)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] ad, input logic [3:0] d, input logic b,
                      input logic [15:0] d16, input logic [1:0] b16);
        we = 1'b1; a = ad; di = d; be = b; di16 = d16; be16 = b16;
        tick;
        we = 1'b0; be = 1'b0; be16 = '0;
    endtask

    task automatic rd(input logic [4:0] ad);
        re = 1'b1; dre = 1'b1; a = ad; dpra = ad;
        tick;
        re = 1'b0; dre = 1'b0;
        repeat (LAT - 1) tick;
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy_rf && cnt < 100) begin
            tick;
            cnt++;
        end
    endtask

    initial begin
        #1;
        tick; tick;
        check("rst_busy", busy_rf, 1);
        check("rst_spo", spo_rf, 0);
        check("rst_spo_vld", spo_vld_rf, 0);
        check("rst_dpo_vld", dpo_vld_wf, 0);

        rst_n = 1'b1;
        wait_idle(n);
        check("rst_sweep_len", n, 32);
        check("rst_busy_ln", busy_ln, 0);
        rd(5'd0);
        check("rd0_spo", spo_rf, 0);
        check("rd0_vld", spo_vld_rf, 1);
        check("rd0_dpo_vld", dpo_vld_rf, 1);
        rd(5'd17);
        check("rd17_dpo", dpo_ln, 0);
        rd(5'd31);
        check("rd31_spo", spo_wf, 0);

        wr(5'd5, 4'hA, 1'b1, 16'h0, 2'b00);
        rd(5'd5);
        check("wr5_spo", spo_rf, 4'hA);
        check("wr5_vld", spo_vld_rf, 1);
        tick;
        check("wr5_vld_drop", spo_vld_rf, 0);
        check("wr5_hold", spo_rf, 4'hA);

        wr(5'd5, 4'hF, 1'b0, 16'h0, 2'b00);
        rd(5'd5);
        check("be0_nowrite", spo_wf, 4'hA);

        wr(5'd9, 4'h3, 1'b1, 16'h0, 2'b00);
        we = 1'b1; a = 5'd9; di = 4'hC; be = 1'b1; re = 1'b1; dre = 1'b1; dpra = 5'd9;
        tick;
        we = 1'b0; be = 1'b0; re = 1'b0; dre = 1'b0;
        repeat (LAT - 1) tick;
        check("coll_dpo_rf", dpo_rf, 4'h3);
        check("coll_dpo_wf", dpo_wf, 4'hC);
        check("coll_spo_rf", spo_rf, 4'h3);
        check("coll_spo_wf", spo_wf, 4'hC);
        rd(5'd9);
        check("coll_after_rf", dpo_rf, 4'hC);

        re = 1'b1; a = 5'd5; dre = 1'b1; dpra = 5'd9;
        tick;
        re = 1'b0; dre = 1'b0;
        repeat (LAT - 1) tick;
        check("dual_spo", spo_rf, 4'hA);
        check("dual_dpo", dpo_rf, 4'hC);

        wr(5'd2, 4'h0, 1'b0, 16'h1234, 2'b11);
        wr(5'd2, 4'h0, 1'b0, 16'hABCD, 2'b01);
        rd(5'd2);
        check("lane_lo", spo_ln, 16'h12CD);
        wr(5'd2, 4'h0, 1'b0, 16'h5678, 2'b10);
        rd(5'd2);
        check("lane_hi", dpo_ln, 16'h56CD);

        wr(5'd7, 4'h6, 1'b1, 16'h0, 2'b00);
        clr = 1'b1; we = 1'b1; a = 5'd7; di = 4'h5; be = 1'b1; re = 1'b1;
        tick;
        clr = 1'b0; we = 1'b0; be = 1'b0; re = 1'b0;
        check("clr_busy", busy_rf, 1);
        vld_seen = spo_vld_rf;
        n = 0;
        while (busy_rf && n < 100) begin
            if (n == 10) begin
                clr = 1'b1; we = 1'b1; a = 5'd3; di = 4'hF; be = 1'b1;
                re = 1'b1; dre = 1'b1; dpra = 5'd3;
            end
            tick;
            clr = 1'b0; we = 1'b0; be = 1'b0; re = 1'b0; dre = 1'b0;
            if (spo_vld_rf || dpo_vld_rf) vld_seen = 1'b1;
            n++;
        end
        check("clr_sweep_len", n, 32);
        check("clr_no_vld", vld_seen, 0);
        rd(5'd3);
        check("clr_rd3", spo_rf, 0);
        rd(5'd7);
        check("clr_rd7", spo_rf, 0);
        rd(5'd9);
        check("clr_rd9", dpo_wf, 0);
        rd(5'd2);
        check("clr_rd2_ln", spo_ln, 0);

        wr(5'd9, 4'hC, 1'b1, 16'h0, 2'b00);
        rd(5'd9);
        clr = 1'b1;
        tick;
        clr = 1'b0;
        repeat (9) tick;
        check("mid_hold", spo_rf, 4'hC);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy_rf, 1);
        check("mid_rst_spo", spo_rf, 0);
        check("mid_rst_vld", spo_vld_rf, 0);
        tick;
        rst_n = 1'b1;
        wait_idle(n);
        check("mid_rst_sweep_len", n, 32);
        rd(5'd9);
        check("mid_rst_rd9", spo_rf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
